// File: rtl/jam_param.sv
// Exhaustive N x N job-assignment solver: loads a cost matrix, walks every
// permutation in lexicographic order and keeps the minimum, its tie count and the first optimum.
module jam_param #(
  parameter int N   = 8,
  parameter int CW  = 7,
  parameter int MCW = 16,
  localparam int IW = (N > 2) ? $clog2(N) : 1,
  localparam int SW = CW + $clog2(N)
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           Start,
  output logic [IW-1:0]  W,
  output logic [IW-1:0]  J,
  input  logic [CW-1:0]  Cost,
  input  logic [IW-1:0]  RdW,
  output logic [IW-1:0]  RdJ,
  output logic [MCW-1:0] MatchCount,
  output logic [SW-1:0]  MinCost,
  output logic           Valid
);

  typedef enum logic [2:0] {
    ST_LOAD = 3'd0,
    ST_EVAL = 3'd1,
    ST_NEXT = 3'd2,
    ST_SWAP = 3'd3,
    ST_REV  = 3'd4,
    ST_DONE = 3'd5
  } state_t;

  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  state_t         state_r;
  logic [CW-1:0]  table_r [N][N];
  logic [IW-1:0]  perm_r  [N];
  logic [IW-1:0]  best_r  [N];
  logic [IW-1:0]  rev_s   [N];
  logic [IW-1:0]  w_r;
  logic [IW-1:0]  j_r;
  logic [IW-1:0]  p_r;
  logic [IW-1:0]  s_r;
  logic [IW-1:0]  p_s;
  logic [IW-1:0]  s_s;
  logic [SW-1:0]  sum_s;
  logic [SW-1:0]  min_r;
  logic [MCW-1:0] cnt_r;
  logic           valid_r;
  logic           last_s;

  // Total cost of the permutation currently held in perm_r.
  always_comb begin
    sum_s = '0;
    for (int i = 0; i < N; i++) begin
      sum_s = sum_s + SW'(table_r[i][perm_r[i]]);
    end
  end

  // Pivot (rightmost ascent) and its successor (rightmost larger element beyond it).
  always_comb begin
    last_s = 1'b1;
    p_s    = '0;
    s_s    = '0;
    for (int i = 0; i < N - 1; i++) begin
      p_s    = (perm_r[i] < perm_r[i+1]) ? IW'(i) : p_s;
      last_s = last_s & ~(perm_r[i] < perm_r[i+1]);
    end
    for (int k = 0; k < N; k++) begin
      s_s = ((IW'(k) > p_s) && (perm_r[k] > perm_r[p_s])) ? IW'(k) : s_s;
    end
  end

  // Tail beyond the latched pivot, mirrored end for end.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      rev_s[i] = (IW'(i) > p_r) ? perm_r[IW'(N - i) + p_r] : perm_r[i];
    end
  end

  // Load / search sequencer with result registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r <= ST_LOAD;
      w_r     <= '0;
      j_r     <= '0;
      p_r     <= '0;
      s_r     <= '0;
      min_r   <= '1;
      cnt_r   <= '0;
      valid_r <= 1'b0;
      for (int i = 0; i < N; i++) begin
        best_r[i] <= IW'(i);
        perm_r[i] <= IW'(i);
      end
    end else begin
      case (state_r)
        ST_LOAD: begin
          table_r[w_r][j_r] <= Cost;
          for (int i = 0; i < N; i++) begin
            perm_r[i] <= IW'(i);
          end
          if (j_r == LAST_IDX) begin
            if (w_r == LAST_IDX) begin
              state_r <= ST_EVAL;
            end else begin
              j_r <= '0;
              w_r <= w_r + IW'(1);
            end
          end else begin
            j_r <= j_r + IW'(1);
          end
        end
        ST_EVAL: begin
          // Ties leave best_r alone so it keeps the lexicographically first optimum.
          if (sum_s < min_r) begin
            min_r <= sum_s;
            cnt_r <= MCW'(1);
            for (int i = 0; i < N; i++) begin
              best_r[i] <= perm_r[i];
            end
          end else if (sum_s == min_r) begin
            if (cnt_r != '1) begin
              cnt_r <= cnt_r + MCW'(1);
            end
          end
          if (last_s) begin
            state_r <= ST_DONE;
            valid_r <= 1'b1;
          end else begin
            state_r <= ST_NEXT;
          end
        end
        ST_NEXT: begin
          p_r     <= p_s;
          s_r     <= s_s;
          state_r <= ST_SWAP;
        end
        ST_SWAP: begin
          perm_r[p_r] <= perm_r[s_r];
          perm_r[s_r] <= perm_r[p_r];
          state_r     <= ST_REV;
        end
        ST_REV: begin
          for (int i = 0; i < N; i++) begin
            perm_r[i] <= rev_s[i];
          end
          state_r <= ST_EVAL;
        end
        ST_DONE: begin
          if (Start) begin
            state_r <= ST_LOAD;
            w_r     <= '0;
            j_r     <= '0;
            min_r   <= '1;
            cnt_r   <= '0;
            valid_r <= 1'b0;
          end
        end
        default: begin
          state_r <= ST_LOAD;
        end
      endcase
    end
  end

  // Best-assignment readout; out-of-range workers read as job 0.
  always_comb begin
    if (int'(RdW) < N) begin
      RdJ = best_r[RdW];
    end else begin
      RdJ = '0;
    end
  end

  assign W          = w_r;
  assign J          = j_r;
  assign MinCost    = min_r;
  assign MatchCount = cnt_r;
  assign Valid      = valid_r;

endmodule

// File: tb/tb_jam_param.sv
// Bench for jam_param: a 4x4 instance (MCW=5) and a 3x3 instance (CW=4, MCW=2, saturating),
// driven by a vector table plus random matrices checked against a brute-force model.
module tb_jam_param;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic       rst_a, start_a, valid_a;
  logic [1:0] w_a, j_a, rdw_a, rdj_a;
  logic [6:0] cost_a;
  logic [4:0] cnt_a;
  logic [8:0] min_a;

  logic       rst_b, start_b, valid_b;
  logic [1:0] w_b, j_b, rdw_b, rdj_b;
  logic [3:0] cost_b;
  logic [1:0] cnt_b;
  logic [5:0] min_b;

  logic [6:0] mat_a [4][4];
  logic [3:0] mat_b [3][3];
  int spec3 [3][3] = '{'{2, 9, 9}, '{9, 9, 1}, '{9, 3, 9}};

  assign cost_a = mat_a[w_a][j_a];
  assign cost_b = (w_b < 2'd3 && j_b < 2'd3) ? mat_b[w_b][j_b] : 4'd0;

  jam_param #(.N(4), .CW(7), .MCW(5)) u_a (
    .CLK(CLK), .RST(rst_a), .Start(start_a), .W(w_a), .J(j_a), .Cost(cost_a),
    .RdW(rdw_a), .RdJ(rdj_a), .MatchCount(cnt_a), .MinCost(min_a), .Valid(valid_a)
  );

  jam_param #(.N(3), .CW(4), .MCW(2)) u_b (
    .CLK(CLK), .RST(rst_b), .Start(start_b), .W(w_b), .J(j_b), .Cost(cost_b),
    .RdW(rdw_b), .RdJ(rdj_b), .MatchCount(cnt_b), .MinCost(min_b), .Valid(valid_b)
  );

  typedef struct {
    int         sel;
    int         kind;
    int         fill;
    int         emin;
    int         ecnt;
    logic [7:0] ebest;
  } vec_t;

  vec_t vecs [11];
  int   n_err, n_chk;
  int   mdl_min, mdl_cnt;
  int   mdl_best [4];
  bit   used [2];

  function automatic int n_of(int sel);   return (sel == 0) ? 4 : 3; endfunction
  function automatic int ones_of(int sel); return (sel == 0) ? 511 : 63; endfunction
  function automatic int cmax_of(int sel); return (sel == 0) ? 31 : 3; endfunction
  function automatic int lat_of(int sel);  return (sel == 0) ? 109 : 30; endfunction
  function automatic int valid_of(int sel); return (sel == 0) ? int'(valid_a) : int'(valid_b); endfunction
  function automatic int min_of(int sel);   return (sel == 0) ? int'(min_a) : int'(min_b); endfunction
  function automatic int cnt_of(int sel);   return (sel == 0) ? int'(cnt_a) : int'(cnt_b); endfunction
  function automatic int w_of(int sel);     return (sel == 0) ? int'(w_a) : int'(w_b); endfunction
  function automatic int j_of(int sel);     return (sel == 0) ? int'(j_a) : int'(j_b); endfunction
  function automatic int cost_of(int sel, int i, int j);
    return (sel == 0) ? int'(mat_a[i][j]) : int'(mat_b[i][j]);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input int sel, input bit r, input bit s);
    if (sel == 0) begin
      rst_a = r; start_a = s;
    end else begin
      rst_b = r; start_b = s;
    end
  endtask

  task automatic read_rdj(input int sel, input int w, output int r);
    if (sel == 0) rdw_a = 2'(w); else rdw_b = 2'(w);
    #1;
    r = (sel == 0) ? int'(rdj_a) : int'(rdj_b);
  endtask

  task automatic set_mat(input int sel, input int kind, input int fill);
    int n, c;
    n = n_of(sel);
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < n; j++) begin
        case (kind)
          0:       c = fill;
          1:       c = (i == j) ? 0 : fill;
          2:       c = (i + j == n - 1) ? 1 : fill;
          3:       c = spec3[i][j];
          default: c = int'($urandom_range(0, fill));
        endcase
        if (sel == 0) mat_a[i][j] = 7'(c); else mat_b[i][j] = 4'(c);
      end
    end
  endtask

  // Brute force: count through all n-digit base-n numbers in order, keep those with distinct digits.
  task automatic model(input int sel);
    int n, total, c, sum, used_mask;
    int d [4];
    bit ok;
    n = n_of(sel);
    total = 1;
    for (int i = 0; i < n; i++) total = total * n;
    mdl_min = 1 << 30;
    mdl_cnt = 0;
    for (int code = 0; code < total; code++) begin
      c = code;
      for (int i = n - 1; i >= 0; i--) begin
        d[i] = c % n;
        c = c / n;
      end
      ok = 1'b1;
      used_mask = 0;
      for (int i = 0; i < n; i++) begin
        if ((used_mask >> d[i]) & 1) ok = 1'b0;
        used_mask = used_mask | (1 << d[i]);
      end
      if (ok) begin
        sum = 0;
        for (int i = 0; i < n; i++) sum = sum + cost_of(sel, i, d[i]);
        if (sum < mdl_min) begin
          mdl_min = sum;
          mdl_cnt = 1;
          for (int i = 0; i < n; i++) mdl_best[i] = d[i];
        end else if (sum == mdl_min && mdl_cnt < cmax_of(sel)) begin
          mdl_cnt++;
        end
      end
    end
  endtask

  task automatic check_idle(input int sel, input string tag);
    check({tag, " valid"}, valid_of(sel), 0);
    check({tag, " W"}, w_of(sel), 0);
    check({tag, " J"}, j_of(sel), 0);
    check({tag, " mincost"}, min_of(sel), ones_of(sel));
    check({tag, " matchcount"}, cnt_of(sel), 0);
  endtask

  // Kick a run by reset or Start; optionally pulse Start again poke_at edges later.
  task automatic run(input int sel, input bit use_rst, input int poke_at, output int cyc);
    drive(sel, use_rst, !use_rst);
    @(posedge CLK);
    #1;
    drive(sel, 1'b0, 1'b0);
    if (!use_rst) check_idle(sel, "restart");
    cyc = 0;
    while (valid_of(sel) == 0 && cyc < 1000) begin
      if (cyc == poke_at) drive(sel, 1'b0, 1'b1);
      @(posedge CLK);
      #1;
      drive(sel, 1'b0, 1'b0);
      cyc++;
    end
  endtask

  task automatic check_result(input int sel, input string tag, input int emin,
                              input int ecnt, input logic [7:0] ebest);
    int r;
    check({tag, " valid"}, valid_of(sel), 1);
    check({tag, " mincost"}, min_of(sel), emin);
    check({tag, " matchcount"}, cnt_of(sel), ecnt);
    for (int w = 0; w < n_of(sel); w++) begin
      read_rdj(sel, w, r);
      check({tag, " rdj"}, r, int'(ebest[2*w +: 2]));
    end
    if (sel == 1) begin
      read_rdj(1, 3, r);
      check({tag, " rdj out of range"}, r, 0);
    end
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [7:0] model_best(int sel);
    logic [7:0] eb;
    eb = 8'h00;
    for (int w = 0; w < n_of(sel); w++) eb[2*w +: 2] = 2'(mdl_best[w]);
    return eb;
  endfunction

  initial begin
    int cyc, r, emin, ecnt;
    logic [7:0] eb;
    n_err = 0;
    n_chk = 0;
    used[0] = 1'b0;
    used[1] = 1'b0;
    rst_a = 1'b1; rst_b = 1'b1; start_a = 1'b0; start_b = 1'b0;
    rdw_a = 2'd0; rdw_b = 2'd0;

    vecs[0]  = '{0, 0, 5,   20, 24, 8'hE4};
    vecs[1]  = '{0, 1, 100, 0,  1,  8'hE4};
    vecs[2]  = '{0, 2, 127, 4,  1,  8'h1B};
    vecs[3]  = '{1, 3, 0,   6,  1,  8'h18};
    vecs[4]  = '{1, 0, 7,   21, 3,  8'h24};
    vecs[5]  = '{0, 4, 3,   -1, -1, 8'h00};
    vecs[6]  = '{1, 4, 2,   -1, -1, 8'h00};
    vecs[7]  = '{0, 4, 127, -1, -1, 8'h00};
    vecs[8]  = '{1, 4, 15,  -1, -1, 8'h00};
    vecs[9]  = '{0, 4, 1,   -1, -1, 8'h00};
    vecs[10] = '{1, 4, 3,   -1, -1, 8'h00};

    set_mat(0, 0, 5);
    set_mat(1, 0, 7);
    repeat (2) @(posedge CLK);
    #1;
    check_idle(0, "reset a");
    check_idle(1, "reset b");
    for (int w = 0; w < 4; w++) begin
      read_rdj(0, w, r);
      check("reset a rdj", r, w);
    end
    for (int w = 0; w < 3; w++) begin
      read_rdj(1, w, r);
      check("reset b rdj", r, w);
    end
    @(posedge CLK);
    #1;

    for (int v = 0; v < 11; v++) begin
      set_mat(vecs[v].sel, vecs[v].kind, vecs[v].fill);
      emin = vecs[v].emin;
      ecnt = vecs[v].ecnt;
      eb   = vecs[v].ebest;
      if (emin < 0) begin
        model(vecs[v].sel);
        emin = mdl_min;
        ecnt = mdl_cnt;
        eb   = model_best(vecs[v].sel);
      end
      run(vecs[v].sel, !used[vecs[v].sel], -1, cyc);
      used[vecs[v].sel] = 1'b1;
      check("latency", cyc, lat_of(vecs[v].sel));
      check_result(vecs[v].sel, "vec", emin, ecnt, eb);
    end

    // Reset in the middle of a load, then a full reload of a different matrix.
    set_mat(0, 4, 127);
    drive(0, 1'b0, 1'b1);
    @(posedge CLK);
    #1;
    drive(0, 1'b0, 1'b0);
    repeat (10) @(posedge CLK);
    #1;
    set_mat(0, 4, 3);
    drive(0, 1'b1, 1'b0);
    @(posedge CLK);
    #1;
    check_idle(0, "midload reset");
    for (int w = 0; w < 4; w++) begin
      read_rdj(0, w, r);
      check("midload reset rdj", r, w);
    end
    model(0);
    run(0, 1'b1, -1, cyc);
    check("midload latency", cyc, lat_of(0));
    check_result(0, "midload", mdl_min, mdl_cnt, model_best(0));

    // Start pulsed while the search sits in EVAL must not disturb it.
    set_mat(0, 4, 5);
    model(0);
    run(0, 1'b0, 20, cyc);
    check("eval start latency", cyc, lat_of(0));
    check_result(0, "eval start", mdl_min, mdl_cnt, model_best(0));
    repeat (6) @(posedge CLK);
    #1;
    check("done hold valid", valid_of(0), 1);
    check("done hold mincost", min_of(0), mdl_min);
    check("done hold matchcount", cnt_of(0), mdl_cnt);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
